vec_alu_execution_unit: RTL and testbench
=========================================

Name: vec_alu_execution_unit

Overview:
Lane-parallel vector integer logic/min-max ALU for the vector execution pipeline. Operates on a full VLEN-bit register group as VLEN/SEW independent elements at SEW = 8, 16 or 32. Supports vector-vector, vector-scalar and vector-immediate operand forms. One registered stage with a done flag.

Parameters:
VLEN, 512, vector register width in bits; must be a multiple of ELEN.
ELEN, 32, maximum element width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
data1  input  VLEN  operand 1: vs1 (VV), scalar in [ELEN-1:0] (VX), or immediate in [4:0] (VI).
data2  input  VLEN  operand 2: vs2, always a full vector.
op_type  input  2  00 OP_VV, 01 OP_VX, 10 OP_VI, 11 illegal.
alu_opcode  input  5  operation select (see Behaviour).
sew  input  7  element width in bits: 8, 16 or 32; any other value is illegal.
alu_result  output  VLEN  registered element-wise result.
alu_done  output  1  registered flag; high when alu_result holds a legal operation's result.

Behaviour:
- Reset (async, active-high): alu_result = 0 and alu_done = 0, immediately and while reset is held.
- Inputs are sampled every rising edge with no handshake. alu_result and alu_done update one cycle after the inputs are sampled. A new operation is accepted every cycle.
- Element i occupies bits [i*SEW +: SEW], for i = 0 .. VLEN/SEW-1. All elements are computed; there is no masking and no vl.
- Operand B per element:
  - VV: data1 element i.
  - VX: data1[SEW-1:0], broadcast to every element.
  - VI: data1[4:0], sign-extended to SEW and broadcast.
- Operand A is data2 element i.
- Opcodes:
  - 00000 AND: A&B.
  - 00001 OR: A|B.
  - 00010 XOR: A^B.
  - 00011 NOT: ~A; operand B is ignored.
  - 00100 MINU: unsigned min.
  - 00101 MIN: signed min.
  - 00110 MAXU: unsigned max.
  - 00111 MAX: signed max.
- Signed compares use two's complement at the current SEW. When A equals B, either value may be returned; the results are identical.
- Illegal sew, illegal op_type, or an unassigned opcode: alu_result <= 0, alu_done <= 0 on that edge.
- Legal operation: alu_done <= 1 on that edge.
- Changing sew between cycles is allowed. Each result reflects the sew sampled with its own operands.
- Reset asserted mid-stream discards the in-flight result.

Optional Feature:
Macro VEC_ALU_SHIFT_EN.
- Defined: opcodes are added as follows.
  - 01000 SLL: A << B[log2(SEW)-1:0].
  - 01001 SRL: logical right shift by the same amount.
  - 01010 SRA: arithmetic right shift by the same amount.
  - Shift amount comes from the low log2(SEW) bits of operand B. In VI form the shift amount is the zero-extended uimm5.
- Not defined: opcodes 01000-01010 are illegal (result 0, done 0).

Decomposition:
- Package vec_alu_pkg holds:
  - enums op_type_e (OP_VV, OP_VX, OP_VI) and alu_op_e (ALU_AND … ALU_MAX, ALU_SLL/SRL/SRA);
  - constants SEW8 = 8, SEW16 = 16, SEW32 = 32.
- One natural sub-module, vec_alu_lane: combinational single-element ALU parameterised by element width.
  - Instantiated in generate loops for 8-, 16- and 32-bit lane sets.
  - The top muxes the lane sets by sew and registers the output.

Test Plan:
- sew=8, VV, AND; data2 elems {F0, AA, 0…}, data1 elems {0F, 0F, 0…} -> next cycle elem0=00, elem1=0A, rest 00, done=1.
- sew=8, VX, OR; scalar data1[7:0]=55, same data2 -> elem0=F5, elem1=FF, rest 55.
- sew=8, VI, XOR; data1[4:0]=11111 (imm -1) -> elem0=0F, elem1=55, rest FF.
- sew=16, NOT; data2 elems {00FF, 0F0F, 0…} -> FF00, F0F0, rest FFFF.
- sew=16, VV, MIN: 10 vs 5 -> elem0=5, rest 0. sew=32, VX, MAXU: data2 elem0=100, scalar 50 -> elem0=100, rest 50.
- sew=32, VV, MAX: -20 vs 10 -> elem0=10. Then sew=12 -> result 0, done 0. Reset asserted mid-run -> outputs 0 immediately.

Source files
------------

// File: rtl/vec_alu_pkg.sv
// Shared types and constants for the vector logic/min-max ALU.
// Optional shift opcodes are enabled with the VEC_ALU_SHIFT_EN macro.
package vec_alu_pkg;

  localparam int unsigned SEW8  = 8;
  localparam int unsigned SEW16 = 16;
  localparam int unsigned SEW32 = 32;

  typedef enum logic [1:0] {
    OP_VV = 2'b00,
    OP_VX = 2'b01,
    OP_VI = 2'b10
  } op_type_e;

  typedef enum logic [4:0] {
    ALU_AND  = 5'b00000,
    ALU_OR   = 5'b00001,
    ALU_XOR  = 5'b00010,
    ALU_NOT  = 5'b00011,
    ALU_MINU = 5'b00100,
    ALU_MIN  = 5'b00101,
    ALU_MAXU = 5'b00110,
    ALU_MAX  = 5'b00111,
    ALU_SLL  = 5'b01000,
    ALU_SRL  = 5'b01001,
    ALU_SRA  = 5'b01010
  } alu_op_e;

  function automatic logic op_legal(input logic [4:0] op);
`ifdef VEC_ALU_SHIFT_EN
    return op <= ALU_SRA;
`else
    return op <= ALU_MAX;
`endif
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// Combinational single-element ALU at a fixed element width.
// Shift opcodes are compiled in only when VEC_ALU_SHIFT_EN is defined.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int unsigned Sew = 8
) (
  input  logic [Sew-1:0] a_i,
  input  logic [Sew-1:0] b_i,
  input  logic [4:0]     op_i,
  output logic [Sew-1:0] res_o
);

`ifdef VEC_ALU_SHIFT_EN
  logic [$clog2(Sew)-1:0] sh_amt;
  assign sh_amt = b_i[$clog2(Sew)-1:0];
`endif

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_AND:  res_o = a_i & b_i;
      ALU_OR:   res_o = a_i | b_i;
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_NOT:  res_o = ~a_i;
      ALU_MINU: res_o = (a_i < b_i) ? a_i : b_i;
      ALU_MIN:  res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      ALU_MAXU: res_o = (a_i > b_i) ? a_i : b_i;
      ALU_MAX:  res_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
`ifdef VEC_ALU_SHIFT_EN
      ALU_SLL:  res_o = a_i << sh_amt;
      ALU_SRL:  res_o = a_i >> sh_amt;
      ALU_SRA:  res_o = $unsigned($signed(a_i) >>> sh_amt);
`endif
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_execution_unit.sv
// Lane-parallel vector ALU: three lane sets (SEW 8/16/32) muxed by sew, one register stage.
// Define VEC_ALU_SHIFT_EN to add the SLL/SRL/SRA opcodes.
module vec_alu_execution_unit
  import vec_alu_pkg::*;
#(
  parameter int unsigned VLEN = 512,
  parameter int unsigned ELEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [VLEN-1:0] data1,
  input  logic [VLEN-1:0] data2,
  input  logic [1:0]      op_type,
  input  logic [4:0]      alu_opcode,
  input  logic [6:0]      sew,
  output logic [VLEN-1:0] alu_result,
  output logic            alu_done
);

  logic [ELEN-1:0]      scalar;
  logic [2:0][VLEN-1:0] res_set;
  logic [VLEN-1:0]      alu_result_d, alu_result_q;
  logic                 alu_done_d, alu_done_q;

  assign scalar = data1[ELEN-1:0];

  // Set s holds VLEN/(8<<s) lanes, each computing one element at width 8<<s.
  for (genvar s = 0; s < 3; s++) begin : g_set
    localparam int unsigned W = 8 << s;
    localparam int unsigned N = VLEN / W;
    logic [VLEN-1:0] set_res;

    for (genvar i = 0; i < N; i++) begin : g_lane
      logic [W-1:0] b;

      always_comb begin
        b = data1[i*W +: W];
        case (op_type)
          OP_VX:   b = scalar[W-1:0];
          OP_VI:   b = {{(W-5){data1[4]}}, data1[4:0]};
          default: b = data1[i*W +: W];
        endcase
      end

      vec_alu_lane #(
        .Sew(W)
      ) u_lane (
        .a_i  (data2[i*W +: W]),
        .b_i  (b),
        .op_i (alu_opcode),
        .res_o(set_res[i*W +: W])
      );
    end

    assign res_set[s] = set_res;
  end

  always_comb begin
    alu_result_d = '0;
    alu_done_d   = 1'b0;
    if (op_type != 2'b11 && op_legal(alu_opcode)) begin
      alu_done_d = 1'b1;
      case (sew)
        7'(SEW8):  alu_result_d = res_set[0];
        7'(SEW16): alu_result_d = res_set[1];
        7'(SEW32): alu_result_d = res_set[2];
        default: begin
          alu_result_d = '0;
          alu_done_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      alu_done_q   <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      alu_done_q   <= alu_done_d;
    end
  end

  assign alu_result = alu_result_q;
  assign alu_done   = alu_done_q;

endmodule

// File: tb/tb_vec_alu_execution_unit.sv
// Self-checking bench for vec_alu_execution_unit: directed cases plus randomized ops
// compared against an element-wise arithmetic reference model.
module tb_vec_alu_execution_unit;

  localparam int unsigned VLEN = 512;
  localparam int unsigned ELEN = 32;

  logic            clk;
  logic            reset;
  logic [VLEN-1:0] data1;
  logic [VLEN-1:0] data2;
  logic [1:0]      op_type;
  logic [4:0]      alu_opcode;
  logic [6:0]      sew;
  logic [VLEN-1:0] alu_result;
  logic            alu_done;

  int n_checks = 0;
  int n_errors = 0;

  vec_alu_execution_unit #(
    .VLEN(VLEN),
    .ELEN(ELEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data1     (data1),
    .data2     (data2),
    .op_type   (op_type),
    .alu_opcode(alu_opcode),
    .sew       (sew),
    .alu_result(alu_result),
    .alu_done  (alu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [VLEN-1:0] got,
                           input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element e0, element e1, every other element = rest.
  function automatic logic [VLEN-1:0] mk(input int sw, input longint e0, input longint e1,
                                         input longint rest);
    logic [VLEN-1:0] v;
    logic [VLEN-1:0] t;
    longint          mask;
    longint          val;
    v    = '0;
    mask = (longint'(1) << sw) - 1;
    for (int i = 0; i < int'(VLEN) / sw; i++) begin
      val       = (i == 0) ? e0 : (i == 1) ? e1 : rest;
      t         = '0;
      t[63:0]   = val & mask;
      v         = v | (t << (i * sw));
    end
    return v;
  endfunction

  function automatic longint to_signed(input longint x, input int sw);
    return (x >= (longint'(1) << (sw - 1))) ? x - (longint'(1) << sw) : x;
  endfunction

  function automatic logic [VLEN-1:0] model(input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2,
                                            input int ot, input int opc, input int sw,
                                            output logic ok);
    logic [VLEN-1:0] res;
    logic [VLEN-1:0] tmp;
    longint          mask, a, b, sa, sb, r, imm;
    ok  = (sw == 8 || sw == 16 || sw == 32) && ot != 3 && opc <= 7;
    res = '0;
    if (!ok) return res;
    mask = (longint'(1) << sw) - 1;
    imm  = longint'(d1[3:0]) - (d1[4] ? 16 : 0);
    for (int i = 0; i < int'(VLEN) / sw; i++) begin
      tmp = d2 >> (i * sw);
      a   = longint'(tmp[31:0]) & mask;
      tmp = d1 >> (i * sw);
      if (ot == 0)      b = longint'(tmp[31:0]) & mask;
      else if (ot == 1) b = longint'(d1[31:0]) & mask;
      else              b = imm & mask;
      sa = to_signed(a, sw);
      sb = to_signed(b, sw);
      case (opc)
        0:       r = a & b;
        1:       r = a | b;
        2:       r = a ^ b;
        3:       r = ~a;
        4:       r = (a < b) ? a : b;
        5:       r = (sa < sb) ? a : b;
        6:       r = (a > b) ? a : b;
        default: r = (sa > sb) ? a : b;
      endcase
      tmp       = '0;
      tmp[63:0] = r & mask;
      res       = res | (tmp << (i * sw));
    end
    return res;
  endfunction

  task automatic run_op(input string tag, input logic [VLEN-1:0] d1, input logic [VLEN-1:0] d2,
                        input logic [1:0] ot, input logic [4:0] opc, input logic [6:0] sw,
                        input logic [VLEN-1:0] exp_res, input logic exp_done);
    @(negedge clk);
    data1      = d1;
    data2      = d2;
    op_type    = ot;
    alu_opcode = opc;
    sew        = sw;
    @(posedge clk);
    #1;
    check_val({tag, "_res"}, alu_result, exp_res);
    check_val({tag, "_done"}, VLEN'(alu_done), VLEN'(exp_done));
  endtask

  initial begin
    logic [VLEN-1:0] d1, d2, exp;
    logic            ok;
    int              sw, ot, opc;
    int              legal_sews[3] = '{8, 16, 32};
    int              bad_sews[5]   = '{0, 12, 64, 127, 4};

    reset = 1'b1; data1 = '0; data2 = '0; op_type = 2'b00; alu_opcode = 5'd0; sew = 7'd8;
    #1;
    check_val("reset_res", alu_result, '0);
    check_val("reset_done", VLEN'(alu_done), '0);
    @(negedge clk);
    reset = 1'b0;

    d2 = mk(8, 'hF0, 'hAA, 0);
    run_op("and8_vv", mk(8, 'h0F, 'h0F, 0), d2, 2'b00, 5'd0, 7'd8, mk(8, 'h00, 'h0A, 'h00), 1'b1);
    run_op("or8_vx", VLEN'(64'h55), d2, 2'b01, 5'd1, 7'd8, mk(8, 'hF5, 'hFF, 'h55), 1'b1);
    run_op("xor8_vi", VLEN'(64'h1F), d2, 2'b10, 5'd2, 7'd8, mk(8, 'h0F, 'h55, 'hFF), 1'b1);
    run_op("not16", '0, mk(16, 'h00FF, 'h0F0F, 0), 2'b00, 5'd3, 7'd16,
           mk(16, 'hFF00, 'hF0F0, 'hFFFF), 1'b1);
    run_op("min16_vv", mk(16, 5, 0, 0), mk(16, 10, 0, 0), 2'b00, 5'd5, 7'd16,
           mk(16, 5, 0, 0), 1'b1);
    run_op("maxu32_vx", VLEN'(64'd50), mk(32, 100, 0, 0), 2'b01, 5'd6, 7'd32,
           mk(32, 100, 50, 50), 1'b1);
    run_op("max32_vv", mk(32, 10, 0, 0), mk(32, -20, 0, 0), 2'b00, 5'd7, 7'd32,
           mk(32, 10, 0, 0), 1'b1);
    run_op("min32_vi_neg", VLEN'(64'h1C), mk(32, 7, -9, 3), 2'b10, 5'd5, 7'd32,
           mk(32, -4, -9, -4), 1'b1);
    run_op("sew12_bad", mk(32, 10, 0, 0), mk(32, -20, 0, 0), 2'b00, 5'd7, 7'd12, '0, 1'b0);
    run_op("optype_bad", d2, d2, 2'b11, 5'd0, 7'd8, '0, 1'b0);
    run_op("opcode_bad", d2, d2, 2'b00, 5'd20, 7'd8, '0, 1'b0);

    // Reset mid-stream: outputs clear asynchronously and an op sampled under reset is dropped.
    run_op("pre_reset", '0, mk(16, 'h00FF, 'h0F0F, 0), 2'b00, 5'd3, 7'd16,
           mk(16, 'hFF00, 'hF0F0, 'hFFFF), 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset_res", alu_result, '0);
    check_val("async_reset_done", VLEN'(alu_done), '0);
    run_op("held_reset", '0, d2, 2'b00, 5'd3, 7'd8, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      for (int w = 0; w < int'(VLEN) / 32; w++) begin
        d1[w*32 +: 32] = $urandom;
        d2[w*32 +: 32] = $urandom;
      end
      if ($urandom_range(0, 7) == 0) d1 = d2;
      sw  = ($urandom_range(0, 9) == 0) ? bad_sews[$urandom_range(0, 4)]
                                        : legal_sews[$urandom_range(0, 2)];
      ot  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      opc = ($urandom_range(0, 9) == 0) ? $urandom_range(11, 31) : $urandom_range(0, 7);
      exp = model(d1, d2, ot, opc, sw, ok);
      run_op($sformatf("rand%0d", n), d1, d2, 2'(ot), 5'(opc), 7'(sw), exp, ok);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
